// File: rtl/cpu_issue_pkg.sv
// Shared constants and types for the ID issue stage.
// Contents: default widths, the "operand unused" Tuse marker, the PC
// written into bubbles, and the stall-cause encoding used by the
// optional perf counters (ISSUE_PERF_EN).
package cpu_issue_pkg;

    localparam int unsigned DEF_NUM_SRC   = 2;
    localparam int unsigned DEF_NUM_FWD   = 2;
    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_ADDR_W    = 5;
    localparam int unsigned DEF_T_W       = 3;
    localparam int unsigned DEF_PAYLOAD_W = 96;

    // A Tuse of all-ones marks a source operand the instruction does not read.
    localparam logic [DEF_T_W-1:0] TUSE_NONE = '1;

    // PC carried by bubbles so EX-stage exception logic sees a benign address.
    localparam logic [31:0] BUBBLE_PC = 32'h0000_3000;

    // Why the issue stage is stalling this cycle.
    typedef enum logic [1:0] {
        CauseNone   = 2'b00,
        CauseHazard = 2'b01,
        CauseMdu    = 2'b10,
        CauseBoth   = 2'b11
    } stall_cause_e;

    function automatic stall_cause_e stall_cause(input logic hazard, input logic mdu);
        return stall_cause_e'({mdu, hazard});
    endfunction

endpackage

// File: rtl/issue_fwd_sel.sv
// Resolves one source operand against all forwarding stages.
// Ports:
//   src_addr/src_data/tuse  - the operand's GPR address, GRF value and Tuse
//   fwd_addr/fwd_tnew/fwd_data - packed per-stage forward info, index 0 nearest
//   data    - operand value to use in ID (forwarded or GRF)
//   hazard  - the nearest producer cannot deliver in time; ID must stall
module issue_fwd_sel
    import cpu_issue_pkg::*;
#(
    parameter int unsigned NUM_FWD = DEF_NUM_FWD,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned T_W     = DEF_T_W
) (
    input  logic [ADDR_W-1:0]         src_addr,
    input  logic [DATA_W-1:0]         src_data,
    input  logic [T_W-1:0]            tuse,
    input  logic [NUM_FWD*ADDR_W-1:0] fwd_addr,
    input  logic [NUM_FWD*T_W-1:0]    fwd_tnew,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    output logic [DATA_W-1:0]         data,
    output logic                      hazard
);

    logic matched;

    // Only the nearest matching stage counts: it holds the youngest write.
    // A producer whose result is not ready yet supplies nothing here; the
    // GRF value passes on and a later stage re-forwards the real result.
    always_comb begin
        data    = src_data;
        hazard  = 1'b0;
        matched = 1'b0;
        if ((src_addr != '0) && !(&tuse)) begin
            for (int unsigned j = 0; j < NUM_FWD; j++) begin
                if (!matched && (fwd_addr[j*ADDR_W +: ADDR_W] == src_addr)) begin
                    matched = 1'b1;
                    if (fwd_tnew[j*T_W +: T_W] > tuse) begin
                        hazard = 1'b1;
                    end
                    if (fwd_tnew[j*T_W +: T_W] == '0) begin
                        data = fwd_data[j*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/id_issue_ctrl.sv
// ID issue stage: Tuse/Tnew hazard detection, priority forwarding for
// NUM_SRC operands over NUM_FWD stages, MDU structural interlock and the
// ID/EX pipeline register.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   in_*              - decoded instruction in ID
//   fwd_*             - destination/Tnew/data held at each forward stage
//   mdu_busy, flush   - MDU computing; kill the instruction in ID
//   id_src_data       - forwarded operands for branch/jr compare (comb)
//   stall             - upstream holds PC and IF/ID (comb)
//   ex_*              - registered ID/EX contents
// Optional: define ISSUE_PERF_EN to add perf_stall_cnt, perf_mdu_stall_cnt
// and perf_issue_cnt saturating counters.
module id_issue_ctrl
    import cpu_issue_pkg::*;
#(
    parameter int unsigned NUM_SRC   = DEF_NUM_SRC,
    parameter int unsigned NUM_FWD   = DEF_NUM_FWD,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned T_W       = DEF_T_W,
    parameter int unsigned PAYLOAD_W = DEF_PAYLOAD_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC*ADDR_W-1:0] in_src_addr,
    input  logic [NUM_SRC*DATA_W-1:0] in_src_data,
    input  logic [NUM_SRC*T_W-1:0]    in_tuse,
    input  logic [ADDR_W-1:0]         in_waddr,
    input  logic [T_W-1:0]            in_tnew,
    input  logic                      in_mdu_op,
    input  logic                      in_mdu_start,
    input  logic [31:0]               in_pc,
    input  logic [PAYLOAD_W-1:0]      in_payload,
    input  logic [NUM_FWD*ADDR_W-1:0] fwd_addr,
    input  logic [NUM_FWD*T_W-1:0]    fwd_tnew,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    input  logic                      mdu_busy,
    input  logic                      flush,
    output logic [NUM_SRC*DATA_W-1:0] id_src_data,
    output logic                      stall,
`ifdef ISSUE_PERF_EN
    output logic [31:0]               perf_stall_cnt,
    output logic [31:0]               perf_mdu_stall_cnt,
    output logic [31:0]               perf_issue_cnt,
`endif
    output logic [NUM_SRC*ADDR_W-1:0] ex_src_addr,
    output logic [NUM_SRC*DATA_W-1:0] ex_src_data,
    output logic [NUM_SRC*T_W-1:0]    ex_tuse,
    output logic [ADDR_W-1:0]         ex_waddr,
    output logic [T_W-1:0]            ex_tnew,
    output logic [31:0]               ex_pc,
    output logic [PAYLOAD_W-1:0]      ex_payload,
    output logic                      ex_mdu_start
);

    logic [NUM_SRC-1:0] hazard;
    logic               mdu_stall;
    logic [T_W-1:0]     tnew_next;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        issue_fwd_sel #(
            .NUM_FWD (NUM_FWD),
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .T_W     (T_W)
        ) u_fwd_sel (
            .src_addr (in_src_addr[i*ADDR_W +: ADDR_W]),
            .src_data (in_src_data[i*DATA_W +: DATA_W]),
            .tuse     (in_tuse[i*T_W +: T_W]),
            .fwd_addr (fwd_addr),
            .fwd_tnew (fwd_tnew),
            .fwd_data (fwd_data),
            .data     (id_src_data[i*DATA_W +: DATA_W]),
            .hazard   (hazard[i])
        );
    end

    // The MDU is occupied either by a running op or by a start sitting in EX
    // that has not raised mdu_busy yet.
    assign mdu_stall = in_mdu_op & (mdu_busy | ex_mdu_start);
    assign stall     = (|hazard) | mdu_stall;

    // Tnew is measured at ID; one cycle later it is one less.
    assign tnew_next = (in_tnew == '0) ? '0 : in_tnew - {{(T_W-1){1'b0}}, 1'b1};

    // Reset, flush and stall all insert the same bubble.
    always_ff @(posedge clk) begin
        if (reset || flush || stall) begin
            ex_src_addr  <= '0;
            ex_src_data  <= '0;
            ex_tuse      <= '1;
            ex_waddr     <= '0;
            ex_tnew      <= '0;
            ex_pc        <= BUBBLE_PC;
            ex_payload   <= '0;
            ex_mdu_start <= 1'b0;
        end else begin
            ex_src_addr  <= in_src_addr;
            ex_src_data  <= id_src_data;
            ex_tuse      <= in_tuse;
            ex_waddr     <= in_waddr;
            ex_tnew      <= tnew_next;
            ex_pc        <= in_pc;
            ex_payload   <= in_payload;
            ex_mdu_start <= in_mdu_start;
        end
    end

`ifdef ISSUE_PERF_EN
    stall_cause_e cause;
    logic         issue_real;

    assign cause = stall_cause(|hazard, mdu_stall);
    // Only loads carrying a real instruction count; an all-zero one is a nop.
    assign issue_real = !flush && !stall && ((in_waddr != '0) || (in_payload != '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cnt     <= '0;
            perf_mdu_stall_cnt <= '0;
            perf_issue_cnt     <= '0;
        end else begin
            if (stall && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if ((cause == CauseMdu) && (perf_mdu_stall_cnt != '1)) begin
                perf_mdu_stall_cnt <= perf_mdu_stall_cnt + 32'd1;
            end
            if (issue_real && (perf_issue_cnt != '1)) begin
                perf_issue_cnt <= perf_issue_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
